// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage.
package wb_stage_pkg;

    localparam int unsigned DEF_XLEN   = 32;
    localparam int unsigned DEF_REG_AW = 5;
    localparam int unsigned RETIRE_W   = 64;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } state_e;

    // Load attributes held while the memory response is outstanding.
    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] offset;
        logic       rd_we;
    } load_ctx_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB handshake, data-memory response and register-file write port.
interface wb_stage_if
    import wb_stage_pkg::*;
#(
    parameter int unsigned XLEN   = DEF_XLEN,
    parameter int unsigned REG_AW = DEF_REG_AW
);
    logic              i_valid;
    logic              o_ready;
    logic [REG_AW-1:0] i_rd_addr;
    logic              i_rd_we;
    logic [XLEN-1:0]   i_alu_result;
    logic              i_is_load;
    logic [2:0]        i_load_funct3;
    logic              i_dmem_rvalid;
    logic [XLEN-1:0]   i_dmem_rdata;
    logic [REG_AW-1:0] o_rd_addr;
    logic [XLEN-1:0]   o_rd_data;
    logic              o_write_en;
    logic              o_fault;
    logic              o_busy;
    logic [RETIRE_W-1:0] o_instret;

    modport master (
        output i_valid, i_rd_addr, i_rd_we, i_alu_result, i_is_load, i_load_funct3,
               i_dmem_rvalid, i_dmem_rdata,
        input  o_ready, o_rd_addr, o_rd_data, o_write_en, o_fault, o_busy, o_instret
    );

    modport slave (
        input  i_valid, i_rd_addr, i_rd_we, i_alu_result, i_is_load, i_load_funct3,
               i_dmem_rvalid, i_dmem_rdata,
        output o_ready, o_rd_addr, o_rd_data, o_write_en, o_fault, o_busy, o_instret
    );
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: selects byte/half at offset, extends, flags misaligned/illegal.
module wb_stage_load_align
    import wb_stage_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data_c,
    output logic            fault_c
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(word >> {offset, 3'b000});
        half_sel = 16'(word >> {offset[1], 4'b0000});
        data_c   = word;
        fault_c  = 1'b0;
        case (funct3)
            F3_LB:  data_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:  begin
                data_c  = {{(XLEN-16){half_sel[15]}}, half_sel};
                fault_c = offset[0];
            end
            F3_LW:  fault_c = (offset != 2'd0);
            F3_LBU: data_c = XLEN'(byte_sel);
            F3_LHU: begin
                data_c  = XLEN'(half_sel);
                fault_c = offset[0];
            end
            default: fault_c = 1'b1;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: register-file writer with load wait/align and fault reporting.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned XLEN   = DEF_XLEN,
    parameter int unsigned REG_AW = DEF_REG_AW
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    wb_stage_if.slave  bus
);
    state_e            state, state_next;
    load_ctx_t         ctx_q, ctx_d;
    logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
    logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic              write_en_q, write_en_d;
    logic              fault_q, fault_d;
    logic              retire_d;
    logic              accept;
    logic [2:0]        al_funct3;
    logic [1:0]        al_offset;
    logic [XLEN-1:0]   al_data;
    logic              al_fault;
    logic              wr;

    assign bus.o_ready = (state == ST_IDLE);
    assign bus.o_busy  = (state == ST_WAIT_LOAD);
    assign accept      = bus.i_valid && bus.o_ready;

    // The aligner checks incoming loads in IDLE and extracts captured loads in WAIT_LOAD.
    assign al_funct3 = (state == ST_IDLE) ? bus.i_load_funct3     : ctx_q.funct3;
    assign al_offset = (state == ST_IDLE) ? bus.i_alu_result[1:0] : ctx_q.offset;

    wb_stage_load_align #(.XLEN(XLEN)) u_load_align (
        .funct3  (al_funct3),
        .offset  (al_offset),
        .word    (bus.i_dmem_rdata),
        .data_c  (al_data),
        .fault_c (al_fault)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (accept && bus.i_is_load && !al_fault) state_next = ST_WAIT_LOAD;
            ST_WAIT_LOAD: if (bus.i_dmem_rvalid) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        write_en_d = 1'b0;
        fault_d    = 1'b0;
        retire_d   = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_data_d  = rd_data_q;
        ctx_d      = ctx_q;
        ld_rd_d    = ld_rd_q;
        wr         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && !bus.i_is_load) begin
                    wr         = bus.i_rd_we && (bus.i_rd_addr != '0);
                    write_en_d = wr;
                    retire_d   = 1'b1;
                    if (wr) begin
                        rd_addr_d = bus.i_rd_addr;
                        rd_data_d = bus.i_alu_result;
                    end
                end else if (accept && al_fault) begin
                    fault_d = 1'b1;
                end else if (accept) begin
                    ctx_d   = '{funct3: bus.i_load_funct3, offset: bus.i_alu_result[1:0],
                                rd_we: bus.i_rd_we};
                    ld_rd_d = bus.i_rd_addr;
                end
            end
            ST_WAIT_LOAD: begin
                if (bus.i_dmem_rvalid) begin
                    wr         = ctx_q.rd_we && (ld_rd_q != '0);
                    write_en_d = wr;
                    retire_d   = 1'b1;
                    if (wr) begin
                        rd_addr_d = ld_rd_q;
                        rd_data_d = al_data;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            write_en_q <= 1'b0;
            fault_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            ctx_q      <= '0;
            ld_rd_q    <= '0;
        end else begin
            write_en_q <= write_en_d;
            fault_q    <= fault_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            ctx_q      <= ctx_d;
            ld_rd_q    <= ld_rd_d;
        end
    end

    assign bus.o_write_en = write_en_q;
    assign bus.o_fault    = fault_q;
    assign bus.o_rd_addr  = rd_addr_q;
    assign bus.o_rd_data  = rd_data_q;

`ifdef WB_RETIRE_CNT_EN
    logic [RETIRE_W-1:0] instret_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      instret_q <= '0;
        else if (retire_d) instret_q <= instret_q + RETIRE_W'(1);
    end

    assign bus.o_instret = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire_d;
    assign bus.o_instret = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; expectations are hand-computed.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [63:0] exp_ret = 64'd0;

    always #5 clk = ~clk;

    wb_stage_if bus ();

    wb_stage dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_valid       = 1'b0;
        bus.i_rd_addr     = '0;
        bus.i_rd_we       = 1'b0;
        bus.i_alu_result  = '0;
        bus.i_is_load     = 1'b0;
        bus.i_load_funct3 = 3'd0;
        bus.i_dmem_rvalid = 1'b0;
        bus.i_dmem_rdata  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.o_ready); end
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        n_checks++; if (bus.o_write_en !== 1'b0 || bus.o_fault !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: we=%b fault=%b want 0 0", bus.o_write_en, bus.o_fault); end
        n_checks++; if (bus.o_rd_addr !== 5'd0 || bus.o_rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd: addr=%0d data=%h want 0 0", bus.o_rd_addr, bus.o_rd_data); end
        n_checks++; if (bus.o_instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret: got %0d want 0", bus.o_instret); end
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ret = 64'd0;
        #1;
    endtask

    task automatic nonload(input logic [4:0] rd, input logic [31:0] alu, input logic we, input string tag);
        logic exp_we;
        exp_we = we && (rd != 5'd0);
        bus.i_valid = 1'b1; bus.i_is_load = 1'b0; bus.i_rd_addr = rd;
        bus.i_alu_result = alu; bus.i_rd_we = we;
        tick();
        bus.i_valid = 1'b0;
        exp_ret++;
        n_checks++; if (bus.o_write_en !== exp_we) begin n_fail++; $display("FAIL %s_we: got %b want %b", tag, bus.o_write_en, exp_we); end
        if (exp_we) begin
            n_checks++; if (bus.o_rd_addr !== rd || bus.o_rd_data !== alu) begin n_fail++; $display("FAIL %s_rd: got %0d/%h want %0d/%h", tag, bus.o_rd_addr, bus.o_rd_data, rd, alu); end
        end
        n_checks++; if (bus.o_ready !== 1'b1 || bus.o_fault !== 1'b0) begin n_fail++; $display("FAIL %s_ready: ready=%b fault=%b want 1 0", tag, bus.o_ready, bus.o_fault); end
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd, input logic we,
                        input logic [31:0] rdata, input int gap, input logic [31:0] exp_data, input string tag);
        logic exp_we;
        exp_we = we && (rd != 5'd0);
        bus.i_valid = 1'b1; bus.i_is_load = 1'b1; bus.i_load_funct3 = f3;
        bus.i_alu_result = addr; bus.i_rd_addr = rd; bus.i_rd_we = we;
        tick();
        bus.i_valid = 1'b0; bus.i_is_load = 1'b0;
        n_checks++; if (bus.o_busy !== 1'b1 || bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL %s_wait: busy=%b ready=%b want 1 0", tag, bus.o_busy, bus.o_ready); end
        repeat (gap - 1) tick();
        n_checks++; if (bus.o_write_en !== 1'b0 || bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL %s_hold: we=%b busy=%b want 0 1", tag, bus.o_write_en, bus.o_busy); end
        bus.i_dmem_rvalid = 1'b1; bus.i_dmem_rdata = rdata;
        tick();
        bus.i_dmem_rvalid = 1'b0;
        exp_ret++;
        n_checks++; if (bus.o_write_en !== exp_we || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL %s_done: we=%b busy=%b want %b 0", tag, bus.o_write_en, bus.o_busy, exp_we); end
        if (exp_we) begin
            n_checks++; if (bus.o_rd_addr !== rd || bus.o_rd_data !== exp_data) begin n_fail++; $display("FAIL %s_data: got %0d/%h want %0d/%h", tag, bus.o_rd_addr, bus.o_rd_data, rd, exp_data); end
        end
        tick();
        n_checks++; if (bus.o_write_en !== 1'b0) begin n_fail++; $display("FAIL %s_pulse: we=%b want 0", tag, bus.o_write_en); end
    endtask

    task automatic fault_load(input logic [2:0] f3, input logic [31:0] addr, input string tag);
        bus.i_valid = 1'b1; bus.i_is_load = 1'b1; bus.i_load_funct3 = f3;
        bus.i_alu_result = addr; bus.i_rd_addr = 5'd9; bus.i_rd_we = 1'b1;
        tick();
        bus.i_valid = 1'b0; bus.i_is_load = 1'b0;
        n_checks++; if (bus.o_fault !== 1'b1 || bus.o_write_en !== 1'b0) begin n_fail++; $display("FAIL %s_fault: fault=%b we=%b want 1 0", tag, bus.o_fault, bus.o_write_en); end
        n_checks++; if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL %s_state: ready=%b busy=%b want 1 0", tag, bus.o_ready, bus.o_busy); end
        tick();
        n_checks++; if (bus.o_fault !== 1'b0) begin n_fail++; $display("FAIL %s_pulse: fault=%b want 0", tag, bus.o_fault); end
    endtask

    task automatic check_instret(input string tag);
        logic [63:0] want;
`ifdef WB_RETIRE_CNT_EN
        want = exp_ret;
`else
        want = 64'd0;
`endif
        n_checks++; if (bus.o_instret !== want) begin n_fail++; $display("FAIL %s_instret: got %0d want %0d", tag, bus.o_instret, want); end
    endtask

    task automatic test_nonload();
        nonload(5'd5, 32'h0000_00A5, 1'b1, "nonload");
        tick();
        n_checks++; if (bus.o_write_en !== 1'b0) begin n_fail++; $display("FAIL nonload_pulse: we=%b want 0", bus.o_write_en); end
    endtask

    task automatic test_back_to_back();
        nonload(5'd6, 32'h0000_0066, 1'b1, "b2b_x6");
        nonload(5'd7, 32'h0000_0077, 1'b1, "b2b_x7");
        nonload(5'd31, 32'hFFFF_0001, 1'b1, "b2b_x31");
        tick();
    endtask

    task automatic test_load();
        load(F3_LB,  32'h0000_1001, 5'd3,  1'b1, 32'h1234_80FF, 3, 32'hFFFF_FF80, "lb");
        load(F3_LBU, 32'h0000_1001, 5'd3,  1'b1, 32'h1234_80FF, 3, 32'h0000_0080, "lbu");
        load(F3_LH,  32'h0000_2002, 5'd10, 1'b1, 32'h8001_0000, 2, 32'hFFFF_8001, "lh");
        load(F3_LHU, 32'h0000_2002, 5'd11, 1'b1, 32'h8001_0000, 1, 32'h0000_8001, "lhu");
        load(F3_LW,  32'h0000_3000, 5'd12, 1'b1, 32'hCAFE_BABE, 1, 32'hCAFE_BABE, "lw");
        load(F3_LB,  32'h0000_4003, 5'd13, 1'b1, 32'h7F00_0000, 2, 32'h0000_007F, "lb_off3");
        check_instret("after_loads");
    endtask

    task automatic test_fault();
        fault_load(F3_LW, 32'h0000_3002, "lw_mis");
        fault_load(3'd3,  32'h0000_3000, "f3_3");
        fault_load(F3_LH, 32'h0000_3001, "lh_mis");
        fault_load(3'd7,  32'h0000_3000, "f3_7");
        check_instret("after_faults");
    endtask

    task automatic test_rd_zero();
        nonload(5'd0, 32'hDEAD_BEEF, 1'b1, "rd0");
        nonload(5'd8, 32'h1111_2222, 1'b0, "nowe");
        check_instret("rd0");
    endtask

    task automatic test_reset_mid_load();
        bus.i_valid = 1'b1; bus.i_is_load = 1'b1; bus.i_load_funct3 = F3_LW;
        bus.i_alu_result = 32'h0000_5000; bus.i_rd_addr = 5'd14; bus.i_rd_we = 1'b1;
        tick();
        bus.i_valid = 1'b0; bus.i_is_load = 1'b0;
        n_checks++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: busy=%b want 1", bus.o_busy); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_async: busy=%b ready=%b want 0 1", bus.o_busy, bus.o_ready); end
        n_checks++; if (bus.o_instret !== 64'd0 || bus.o_rd_addr !== 5'd0) begin n_fail++; $display("FAIL midrst_outs: instret=%0d addr=%0d want 0 0", bus.o_instret, bus.o_rd_addr); end
        #3 rst_n = 1'b1;
        exp_ret = 64'd0;
        bus.i_dmem_rvalid = 1'b1; bus.i_dmem_rdata = 32'h7777_7777;
        tick();
        bus.i_dmem_rvalid = 1'b0;
        n_checks++; if (bus.o_write_en !== 1'b0 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_stale: we=%b busy=%b want 0 0", bus.o_write_en, bus.o_busy); end
    endtask

    task automatic test_spurious();
        bus.i_dmem_rvalid = 1'b1; bus.i_dmem_rdata = 32'h5555_5555;
        tick();
        n_checks++; if (bus.o_write_en !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL spurious: we=%b busy=%b ready=%b want 0 0 1", bus.o_write_en, bus.o_busy, bus.o_ready); end
        // rvalid present in the acceptance cycle must not complete the load
        bus.i_valid = 1'b1; bus.i_is_load = 1'b1; bus.i_load_funct3 = F3_LW;
        bus.i_alu_result = 32'h0000_6000; bus.i_rd_addr = 5'd15; bus.i_rd_we = 1'b1;
        tick();
        bus.i_valid = 1'b0; bus.i_is_load = 1'b0;
        bus.i_dmem_rvalid = 1'b0;
        n_checks++; if (bus.o_write_en !== 1'b0 || bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL accept_rvalid: we=%b busy=%b want 0 1", bus.o_write_en, bus.o_busy); end
        bus.i_dmem_rvalid = 1'b1; bus.i_dmem_rdata = 32'h1122_3344;
        tick();
        bus.i_dmem_rvalid = 1'b0;
        exp_ret++;
        n_checks++; if (bus.o_write_en !== 1'b1 || bus.o_rd_addr !== 5'd15 || bus.o_rd_data !== 32'h1122_3344) begin n_fail++; $display("FAIL accept_rvalid_data: we=%b got %0d/%h want 1 15/11223344", bus.o_write_en, bus.o_rd_addr, bus.o_rd_data); end
        tick();
    endtask

    task automatic test_retire_count();
        logic [63:0] want;
        test_reset();
        nonload(5'd1, 32'h0000_0001, 1'b1, "rc1");
        nonload(5'd2, 32'h0000_0002, 1'b1, "rc2");
        nonload(5'd3, 32'h0000_0003, 1'b0, "rc3");
        nonload(5'd0, 32'h0000_0004, 1'b1, "rc4");
        load(F3_LW,  32'h0000_0100, 5'd4, 1'b1, 32'hA5A5_5A5A, 1, 32'hA5A5_5A5A, "rc5");
        load(F3_LB,  32'h0000_0100, 5'd5, 1'b0, 32'h0000_0080, 1, 32'hFFFF_FF80, "rc6");
        fault_load(F3_LW, 32'h0000_0101, "rc7");
        load(F3_LHU, 32'h0000_0102, 5'd6, 1'b1, 32'hBEEF_0000, 2, 32'h0000_BEEF, "rc8");
        nonload(5'd7, 32'h0000_0009, 1'b1, "rc9");
        load(F3_LBU, 32'h0000_0103, 5'd0, 1'b1, 32'hFF00_0000, 1, 32'h0000_00FF, "rc10");
`ifdef WB_RETIRE_CNT_EN
        want = 64'd9;
`else
        want = 64'd0;
`endif
        n_checks++; if (bus.o_instret !== want) begin n_fail++; $display("FAIL retire_count: got %0d want %0d", bus.o_instret, want); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_nonload();
        test_back_to_back();
        test_load();
        test_fault();
        test_rd_zero();
        test_reset_mid_load();
        test_spurious();
        test_retire_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
